// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The frame is: 16-bit word count (MSB first), 4*count payload bytes, XOR checksum.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR_HI,
        HDR_LO,
        DATA,
        CHK,
        DONE,
        ERR
    } state_t;

    localparam int CNT_W     = 16;
    localparam int HDR_BYTES = 2;
    // A byte total of 4*count needs two more bits than the word count.
    localparam int TOTAL_W   = CNT_W + 2;

endpackage

// File: rtl/imem_loader.sv
// Loads instruction memory from a framed byte stream and holds the CPU in reset
// until a load finishes with a matching checksum.
//
// state  | meaning
// IDLE   | out of reset, nothing loaded, CPU held
// HDR_HI | waiting for word-count high byte
// HDR_LO | waiting for word-count low byte, size check
// DATA   | payload bytes written to consecutive addresses
// CHK    | waiting for checksum byte (never written)
// DONE   | load good, CPU released
// ERR    | overflow or checksum failure, CPU held
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int MEM_BYTES = 512,
    parameter int ADDR_W    = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

    localparam logic [TOTAL_W-1:0] MEM_TOTAL = TOTAL_W'(MEM_BYTES);

    state_t             state, state_next;
    logic [7:0]         cnt_hi;
    logic [TOTAL_W-1:0] byte_total;
    logic [TOTAL_W-1:0] total_in;
    // One spare bit so the address cannot wrap after the final byte of a full memory.
    logic [ADDR_W:0]    addr;
    logic [7:0]         xsum;
    logic               xfer;
    logic               last_byte;

    assign xfer      = byte_valid && byte_ready;
    assign total_in  = {cnt_hi, byte_data, 2'b00};
    assign last_byte = (TOTAL_W'(addr) == (byte_total - TOTAL_W'(1)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        byte_ready = 1'b0;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) state_next = HDR_HI;
            end
            HDR_HI: begin
                byte_ready = 1'b1;
                if (xfer) state_next = HDR_LO;
            end
            HDR_LO: begin
                byte_ready = 1'b1;
                if (xfer) begin
                    if (total_in > MEM_TOTAL)  state_next = ERR;
                    else if (total_in == '0)   state_next = CHK;
                    else                       state_next = DATA;
                end
            end
            DATA: begin
                byte_ready = 1'b1;
                if (xfer && last_byte) state_next = CHK;
            end
            CHK: begin
                byte_ready = 1'b1;
                if (xfer) state_next = (byte_data == xsum) ? DONE : ERR;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_hi     <= '0;
            byte_total <= '0;
            addr       <= '0;
            xsum       <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            wr_en <= 1'b0;
            if (state_next == HDR_HI && state != HDR_HI) begin
                addr <= '0;
                xsum <= '0;
            end
            if (state == HDR_HI && xfer) cnt_hi <= byte_data;
            if (state == HDR_LO && xfer) begin
                byte_total <= total_in;
                addr       <= '0;
                xsum       <= '0;
            end
            if (state == DATA && xfer) begin
                wr_en   <= 1'b1;
                wr_addr <= addr[ADDR_W-1:0];
                wr_data <= byte_data;
                xsum    <= xsum ^ byte_data;
                addr    <= addr + 1'b1;
            end
        end
    end

    // Status follows the next state so it lines up with the DONE/ERR entry edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_done <= 1'b0;
            load_err  <= 1'b0;
            cpu_hold  <= 1'b1;
        end else begin
            load_done <= (state_next == DONE);
            load_err  <= (state_next == ERR);
            cpu_hold  <= (state_next != DONE);
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framed loads, stalls, bad checksum, size limits,
// zero count, reset mid-load and an ignored start during payload.
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready;
    logic       wr_en;
    logic [8:0] wr_addr;
    logic [7:0] wr_data;
    logic       cpu_hold;
    logic       load_done;
    logic       load_err;

    int vectors     = 0;
    int miscompares = 0;
    int hold_wr     = 0;

    logic [8:0] wa_q[$];
    logic [7:0] wd_q[$];
    logic [7:0] frame_q[$];

    imem_loader #(.MEM_BYTES(512), .ADDR_W(9)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
            if (cpu_hold !== 1'b1) hold_wr++;
        end
    end

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int stall, output logic rdy_ok);
        int n;
        rdy_ok = 1'b1;
        for (int s = 0; s < stall; s++) begin
            byte_valid = 1'b0;
            @(posedge clk); #1;
            if (byte_ready !== 1'b1) rdy_ok = 1'b0;
        end
        byte_valid = 1'b1;
        byte_data  = b;
        n = 0;
        while (byte_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) begin
            vectors++;
            miscompares++;
            $display("FAIL send_byte_timeout: byte_ready=%b required 1", byte_ready);
        end
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_frame(input int stall, output logic rdy_ok);
        logic ok;
        rdy_ok = 1'b1;
        foreach (frame_q[i]) begin
            send_byte(frame_q[i], stall, ok);
            if (!ok) rdy_ok = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({byte_ready, wr_en, cpu_hold, load_done, load_err} !== 5'b00100) begin
            miscompares++;
            $display("FAIL reset_outputs: ready/wr_en/hold/done/err=%b required 00100",
                     {byte_ready, wr_en, cpu_hold, load_done, load_err});
        end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [7:0] exp_d[4] = '{8'h24, 8'h01, 8'h00, 8'h01};
        logic ok;
        clear_log();
        pulse_start();
        frame_q = '{8'h00, 8'h01, 8'h24, 8'h01, 8'h00, 8'h01, 8'h24};
        send_frame(0, ok);
        vectors++;
        if (wa_q.size() !== 4) begin
            miscompares++;
            $display("FAIL basic_wr_count: got %0d required 4", wa_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (wa_q[i] !== 9'(i) || wd_q[i] !== exp_d[i]) begin
                    miscompares++;
                    $display("FAIL basic_write%0d: addr=%0d data=%h required addr=%0d data=%h",
                             i, wa_q[i], wd_q[i], i, exp_d[i]);
                end
            end
        end
        vectors++;
        if ({load_done, cpu_hold, load_err} !== 3'b100) begin
            miscompares++;
            $display("FAIL basic_status: done/hold/err=%b required 100", {load_done, cpu_hold, load_err});
        end
    endtask

    task automatic test_stall();
        logic [7:0] exp_d[4] = '{8'h24, 8'h01, 8'h00, 8'h01};
        logic ok;
        clear_log();
        pulse_start();
        frame_q = '{8'h00, 8'h01, 8'h24, 8'h01, 8'h00, 8'h01, 8'h24};
        send_frame(3, ok);
        vectors++;
        if (ok !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_ready: byte_ready dropped during stall, required 1");
        end
        vectors++;
        if (wa_q.size() !== 4) begin
            miscompares++;
            $display("FAIL stall_wr_count: got %0d required 4", wa_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (wa_q[i] !== 9'(i) || wd_q[i] !== exp_d[i]) begin
                    miscompares++;
                    $display("FAIL stall_write%0d: addr=%0d data=%h required addr=%0d data=%h",
                             i, wa_q[i], wd_q[i], i, exp_d[i]);
                end
            end
        end
        vectors++;
        if ({load_done, cpu_hold, load_err} !== 3'b100) begin
            miscompares++;
            $display("FAIL stall_status: done/hold/err=%b required 100", {load_done, cpu_hold, load_err});
        end
    endtask

    task automatic test_bad_checksum();
        logic ok;
        clear_log();
        pulse_start();
        vectors++;
        if ({load_done, cpu_hold} !== 2'b01) begin
            miscompares++;
            $display("FAIL restart_clears: done/hold=%b required 01", {load_done, cpu_hold});
        end
        frame_q = '{8'h00, 8'h01, 8'h24, 8'h01, 8'h00, 8'h01, 8'h25};
        send_frame(0, ok);
        vectors++;
        if (wa_q.size() !== 4) begin
            miscompares++;
            $display("FAIL badsum_wr_count: got %0d required 4", wa_q.size());
        end
        vectors++;
        if ({load_err, load_done, cpu_hold} !== 3'b101) begin
            miscompares++;
            $display("FAIL badsum_status: err/done/hold=%b required 101", {load_err, load_done, cpu_hold});
        end
    endtask

    task automatic test_overflow();
        logic ok;
        clear_log();
        pulse_start();
        frame_q = '{8'h00, 8'h81};
        send_frame(0, ok);
        repeat (2) @(negedge clk);
        vectors++;
        if ({load_err, load_done, cpu_hold, byte_ready} !== 4'b1010) begin
            miscompares++;
            $display("FAIL overflow_status: err/done/hold/ready=%b required 1010",
                     {load_err, load_done, cpu_hold, byte_ready});
        end
        vectors++;
        if (wa_q.size() !== 0) begin
            miscompares++;
            $display("FAIL overflow_writes: got %0d required 0", wa_q.size());
        end
    endtask

    task automatic test_full_memory();
        logic       ok;
        logic [7:0] xs;
        logic [7:0] b;
        int         errs;
        clear_log();
        pulse_start();
        frame_q = '{8'h00, 8'h80};
        xs = 8'h00;
        for (int i = 0; i < 512; i++) begin
            b = 8'((i * 7) + 3);
            frame_q.push_back(b);
            xs = xs ^ b;
        end
        frame_q.push_back(xs);
        send_frame(0, ok);
        vectors++;
        if (wa_q.size() !== 512) begin
            miscompares++;
            $display("FAIL full_wr_count: got %0d required 512", wa_q.size());
        end else begin
            errs = 0;
            for (int i = 0; i < 512; i++)
                if (wa_q[i] !== 9'(i) || wd_q[i] !== 8'((i * 7) + 3)) errs++;
            vectors++;
            if (errs !== 0) begin
                miscompares++;
                $display("FAIL full_contents: %0d bad writes required 0", errs);
            end
            vectors++;
            if (wa_q[511] !== 9'd511) begin
                miscompares++;
                $display("FAIL full_last_addr: got %0d required 511", wa_q[511]);
            end
        end
        vectors++;
        if ({load_done, cpu_hold, load_err} !== 3'b100) begin
            miscompares++;
            $display("FAIL full_status: done/hold/err=%b required 100", {load_done, cpu_hold, load_err});
        end
    endtask

    task automatic test_zero_count();
        logic ok;
        clear_log();
        pulse_start();
        frame_q = '{8'h00, 8'h00, 8'h00};
        send_frame(0, ok);
        vectors++;
        if (wa_q.size() !== 0) begin
            miscompares++;
            $display("FAIL zero_writes: got %0d required 0", wa_q.size());
        end
        vectors++;
        if ({load_done, cpu_hold, load_err} !== 3'b100) begin
            miscompares++;
            $display("FAIL zero_status: done/hold/err=%b required 100", {load_done, cpu_hold, load_err});
        end
    endtask

    task automatic test_reset_reload();
        logic ok;
        clear_log();
        pulse_start();
        frame_q = '{8'h00, 8'h01, 8'h24, 8'h01};
        send_frame(0, ok);
        #1;
        rst = 1'b0;
        #1;
        vectors++;
        if ({byte_ready, wr_en, cpu_hold, load_done, load_err} !== 5'b00100) begin
            miscompares++;
            $display("FAIL midload_reset: ready/wr_en/hold/done/err=%b required 00100",
                     {byte_ready, wr_en, cpu_hold, load_done, load_err});
        end
        byte_valid = 1'b1;
        byte_data  = 8'h55;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        byte_valid = 1'b0;
        vectors++;
        if (byte_ready !== 1'b0 || cpu_hold !== 1'b1) begin
            miscompares++;
            $display("FAIL after_reset_idle: ready=%b hold=%b required 0 1", byte_ready, cpu_hold);
        end
        vectors++;
        if (wa_q.size() !== 2) begin
            miscompares++;
            $display("FAIL reset_writes: got %0d required 2", wa_q.size());
        end
        test_basic();
    endtask

    task automatic test_start_ignored();
        logic ok;
        clear_log();
        pulse_start();
        frame_q = '{8'h00, 8'h01, 8'h11, 8'h22};
        send_frame(0, ok);
        pulse_start();
        frame_q = '{8'h33, 8'h44, 8'h44};
        send_frame(0, ok);
        vectors++;
        if (wa_q.size() !== 4) begin
            miscompares++;
            $display("FAIL ignore_start_count: got %0d required 4", wa_q.size());
        end else begin
            vectors++;
            if (wa_q[3] !== 9'd3 || wd_q[3] !== 8'h44) begin
                miscompares++;
                $display("FAIL ignore_start_last: addr=%0d data=%h required 3 44", wa_q[3], wd_q[3]);
            end
        end
        vectors++;
        if ({load_done, cpu_hold, load_err} !== 3'b100) begin
            miscompares++;
            $display("FAIL ignore_start_status: done/hold/err=%b required 100",
                     {load_done, cpu_hold, load_err});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_bad_checksum();
        test_overflow();
        test_full_memory();
        test_zero_count();
        test_reset_reload();
        test_start_ignored();
        vectors++;
        if (hold_wr !== 0) begin
            miscompares++;
            $display("FAIL write_while_released: got %0d required 0", hold_wr);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
